// File: rtl/ddr_rd_burst_sched_if.sv
// rtl/ddr_rd_burst_sched_if.sv - AXI read channel and output FIFO write port of the capture read-back scheduler
interface ddr_rd_burst_sched_if #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH      = 64
);
    logic [CTRL_ADDR_WIDTH-1:0] axi_araddr;
    logic [3:0]                 axi_arlen;
    logic                       axi_arvalid;
    logic                       axi_arready;
    logic [DATA_WIDTH-1:0]      axi_rdata;
    logic                       axi_rvalid;
    logic                       axi_rlast;
    logic                       fifo_alfull;
    logic [DATA_WIDTH-1:0]      fifo_wdata;
    logic                       fifo_wen;

    modport master (
        output axi_araddr, axi_arlen, axi_arvalid,
        input  axi_arready, axi_rdata, axi_rvalid, axi_rlast, fifo_alfull,
        output fifo_wdata, fifo_wen
    );

    modport slave (
        input  axi_araddr, axi_arlen, axi_arvalid,
        output axi_arready, axi_rdata, axi_rvalid, axi_rlast, fifo_alfull,
        input  fifo_wdata, fifo_wen
    );
endinterface

// File: rtl/ddr_rd_burst_sched.sv
// rtl/ddr_rd_burst_sched.sv - splits a capture read job into single-outstanding AXI bursts gated by FIFO space
module ddr_rd_burst_sched #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH      = 64,
    parameter int LEN_WIDTH       = 11,
    parameter int MAX_BURST       = 16,
    parameter int ADDR_STEP       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_start,
    input  logic [CTRL_ADDR_WIDTH-1:0] rd_addr,
    input  logic [LEN_WIDTH-1:0]       rd_len,
    output logic                       rd_busy,
    output logic                       rd_done,
    output logic                       rd_err,
    ddr_rd_burst_sched_if.master       bus
);
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ADDR, S_DATA, S_DONE} state_t;

    state_t                     state, state_nxt;
    logic [CTRL_ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
    logic [LEN_WIDTH-1:0]       remain, remain_nxt;
    logic [4:0]                 blen, blen_nxt, beat_cnt, beat_cnt_nxt;
    logic [CTRL_ADDR_WIDTH-1:0] araddr_nxt;
    logic [3:0]                 arlen_nxt;
    logic                       arvalid_nxt, busy_nxt, done_nxt, err_nxt;
    logic [4:0]                 blen_calc;
    logic                       last_beat;

    assign blen_calc = (remain < LEN_WIDTH'(MAX_BURST)) ? 5'(remain) : 5'(MAX_BURST);
    assign last_beat = (beat_cnt + 5'd1) == blen;

    always_comb begin
        state_nxt    = state;
        cur_addr_nxt = cur_addr;
        remain_nxt   = remain;
        blen_nxt     = blen;
        beat_cnt_nxt = beat_cnt;
        araddr_nxt   = bus.axi_araddr;
        arlen_nxt    = bus.axi_arlen;
        arvalid_nxt  = bus.axi_arvalid;
        busy_nxt     = rd_busy;
        done_nxt     = 1'b0;
        err_nxt      = rd_err;
        case (state)
            S_IDLE: begin
                if (rd_start) begin
                    if (rd_len != '0) begin
                        cur_addr_nxt = rd_addr;
                        remain_nxt   = rd_len;
                        err_nxt      = 1'b0;
                        busy_nxt     = 1'b1;
                        state_nxt    = S_CHECK;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            // R has no back-pressure, so a burst is only requested once the FIFO can take all of it
            S_CHECK: begin
                if (!bus.fifo_alfull) begin
                    blen_nxt     = blen_calc;
                    araddr_nxt   = cur_addr;
                    arlen_nxt    = 4'(blen_calc - 5'd1);
                    arvalid_nxt  = 1'b1;
                    beat_cnt_nxt = '0;
                    state_nxt    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.axi_arready) begin
                    arvalid_nxt  = 1'b0;
                    cur_addr_nxt = cur_addr + CTRL_ADDR_WIDTH'(blen) * CTRL_ADDR_WIDTH'(ADDR_STEP);
                    remain_nxt   = remain - LEN_WIDTH'(blen);
                    state_nxt    = S_DATA;
                end
            end
            // burst length is trusted over rlast; a disagreement only raises the sticky error
            S_DATA: begin
                if (bus.axi_rvalid) begin
                    beat_cnt_nxt = beat_cnt + 5'd1;
                    if (bus.axi_rlast != last_beat) begin
                        err_nxt = 1'b1;
                    end
                    if (last_beat) begin
                        if (remain == '0) begin
                            done_nxt  = 1'b1;
                            busy_nxt  = 1'b0;
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_CHECK;
                        end
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            cur_addr        <= '0;
            remain          <= '0;
            blen            <= '0;
            beat_cnt        <= '0;
            bus.axi_araddr  <= '0;
            bus.axi_arlen   <= '0;
            bus.axi_arvalid <= 1'b0;
            rd_busy         <= 1'b0;
            rd_done         <= 1'b0;
            rd_err          <= 1'b0;
            bus.fifo_wen    <= 1'b0;
            bus.fifo_wdata  <= '0;
        end else begin
            state           <= state_nxt;
            cur_addr        <= cur_addr_nxt;
            remain          <= remain_nxt;
            blen            <= blen_nxt;
            beat_cnt        <= beat_cnt_nxt;
            bus.axi_araddr  <= araddr_nxt;
            bus.axi_arlen   <= arlen_nxt;
            bus.axi_arvalid <= arvalid_nxt;
            rd_busy         <= busy_nxt;
            rd_done         <= done_nxt;
            rd_err          <= err_nxt;
            bus.fifo_wen    <= bus.axi_rvalid;
            bus.fifo_wdata  <= bus.axi_rdata;
        end
    end
endmodule
